// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and the oversample divider computation.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int calc_div(input int clk_freq, input int baud_rate, input int ovs);
        int div_s;
        div_s = clk_freq / (baud_rate * ovs);
        if (div_s < 1) begin
            return 1;
        end else begin
            return div_s;
        end
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line in, byte/handshake and error pulses out.
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_err;
    logic       overrun;

    modport master (input rx, input rx_ready,
                    output rx_data, output rx_valid, output framing_err, output overrun);
    modport slave  (output rx, output rx_ready,
                    input rx_data, input rx_valid, input framing_err, input overrun);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
module uart_baud_tick #(
    parameter int DIV = 6
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Divider counter with registered tick output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling, valid/ready output
// holding one byte, and framing/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD_RATE = 9600,
    parameter int OVS       = 16
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int            DIV      = calc_div(CLK_FREQ, BAUD_RATE, OVS);
    localparam int            TW       = $clog2(OVS);
    localparam logic [TW-1:0] MID_TICK = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] BIT_TICK = TW'(OVS - 1);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] START = ST_START;
    localparam logic [1:0] DATA  = ST_DATA;
    localparam logic [1:0] STOP  = ST_STOP;

    logic          sync1_r, sync2_r;
    logic          tick_s;
    logic [1:0]    state_r;
    logic          armed_r;
    logic [TW-1:0] tcnt_r;
    logic [2:0]    bcnt_r;
    logic [7:0]    shift_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;
    logic          framing_err_r;
    logic          overrun_r;
    logic          stop_sample_s, stop_ok_s, stop_bad_s;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Two-flop synchronizer for the asynchronous line, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= bus.rx;
            sync2_r <= sync1_r;
        end
    end

    assign stop_sample_s = tick_s && (state_r == STOP) && (tcnt_r == BIT_TICK);
    assign stop_ok_s     = stop_sample_s && sync2_r;
    assign stop_bad_s    = stop_sample_s && !sync2_r;

    // Frame FSM; every advance happens on an oversample tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            armed_r <= 1'b0;
            tcnt_r  <= '0;
            bcnt_r  <= 3'd0;
            shift_r <= 8'h00;
        end else if (tick_s) begin
            case (state_r)
                IDLE: begin
                    // A start edge only counts once the line was seen idle high.
                    if (sync2_r) begin
                        armed_r <= 1'b1;
                    end else if (armed_r) begin
                        state_r <= START;
                        tcnt_r  <= '0;
                    end
                end
                START: begin
                    if (tcnt_r == MID_TICK) begin
                        tcnt_r  <= '0;
                        bcnt_r  <= 3'd0;
                        state_r <= sync2_r ? IDLE : DATA;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                DATA: begin
                    if (tcnt_r == BIT_TICK) begin
                        tcnt_r  <= '0;
                        shift_r <= {sync2_r, shift_r[7:1]};
                        bcnt_r  <= bcnt_r + 3'd1;
                        if (bcnt_r == 3'd7) begin
                            state_r <= STOP;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                STOP: begin
                    if (tcnt_r == BIT_TICK) begin
                        tcnt_r  <= '0;
                        state_r <= IDLE;
                        if (!sync2_r) begin
                            armed_r <= 1'b0;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output holding register with valid/ready handshake and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            framing_err_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            framing_err_r <= stop_bad_s;
            overrun_r     <= 1'b0;
            if (stop_ok_s) begin
                if (!rx_valid_r || bus.rx_ready) begin
                    rx_data_r  <= shift_r;
                    rx_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (rx_valid_r && bus.rx_ready) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    assign bus.rx_data     = rx_data_r;
    assign bus.rx_valid    = rx_valid_r;
    assign bus.framing_err = framing_err_r;
    assign bus.overrun     = overrun_r;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against an expected-byte queue built from the frame rules.
module tb_uart_rx;
    localparam int CLK_FREQ  = 1000000;
    localparam int BAUD_RATE = 9600;
    localparam int OVS       = 16;
    localparam int BIT       = (CLK_FREQ / (BAUD_RATE * OVS)) * OVS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus ();

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVS(OVS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int         got_n     = 0;
    int         valid_cyc = 0;
    int         fe_cyc    = 0;
    int         ov_cyc    = 0;
    logic [7:0] got_mem [0:255];

    // Monitor: record accepted bytes and count output pulse cycles.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) valid_cyc <= valid_cyc + 1;
        if (bus.framing_err === 1'b1) fe_cyc <= fe_cyc + 1;
        if (bus.overrun === 1'b1) ov_cyc <= ov_cyc + 1;
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) begin
            got_mem[got_n[7:0]] <= bus.rx_data;
            got_n <= got_n + 1;
        end
    end

    task automatic drive(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        drive(stop, BIT);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rx = 1'b1;
        bus.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
        checks++; if (bus.framing_err !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++; $display("FAIL reset_pulses: fe=%b ov=%b want 0 0", bus.framing_err, bus.overrun); end
        rst = 1'b0;
        drive(1'b1, 30);
    endtask

    task automatic test_basic;
        int g0, v0, f0, o0;
        g0 = got_n; v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'hA5, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", got_n - g0); end
        checks++; if (got_mem[g0[7:0]] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", got_mem[g0[7:0]]); end
        checks++; if (valid_cyc - v0 !== 1) begin errors++; $display("FAIL basic_valid_len: got %0d want 1", valid_cyc - v0); end
        checks++; if (fe_cyc - f0 !== 0 || ov_cyc - o0 !== 0) begin
            errors++; $display("FAIL basic_err: fe=%0d ov=%0d want 0 0", fe_cyc - f0, ov_cyc - o0); end
    endtask

    task automatic test_glitch;
        int g0, v0, f0;
        g0 = got_n; v0 = valid_cyc; f0 = fe_cyc;
        drive(1'b0, 30);
        drive(1'b1, 150);
        checks++; if (valid_cyc - v0 !== 0 || fe_cyc - f0 !== 0) begin
            errors++; $display("FAIL glitch_quiet: valid=%0d fe=%0d want 0 0", valid_cyc - v0, fe_cyc - f0); end
        send_frame(8'h3C, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== 1) begin errors++; $display("FAIL glitch_count: got %0d want 1", got_n - g0); end
        checks++; if (got_mem[g0[7:0]] !== 8'h3C) begin errors++; $display("FAIL glitch_data: got %h want 3c", got_mem[g0[7:0]]); end
    endtask

    task automatic test_framing;
        int g0, v0, f0;
        g0 = got_n; v0 = valid_cyc; f0 = fe_cyc;
        send_frame(8'h55, 1'b0);
        drive(1'b1, 100);
        checks++; if (fe_cyc - f0 !== 1) begin errors++; $display("FAIL framing_pulse: got %0d want 1", fe_cyc - f0); end
        checks++; if (valid_cyc - v0 !== 0) begin errors++; $display("FAIL framing_valid: got %0d want 0", valid_cyc - v0); end
        send_frame(8'h0F, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h0F) begin
            errors++; $display("FAIL framing_next: count %0d data %h want 1 0f", got_n - g0, got_mem[g0[7:0]]); end
        checks++; if (fe_cyc - f0 !== 1) begin errors++; $display("FAIL framing_next_fe: got %0d want 1", fe_cyc - f0); end
    endtask

    task automatic test_overrun;
        int g0, o0;
        bus.rx_ready = 1'b0;
        g0 = got_n; o0 = ov_cyc;
        send_frame(8'h11, 1'b1);
        drive(1'b1, 20);
        checks++; if (ov_cyc - o0 !== 0) begin errors++; $display("FAIL overrun_early: got %0d want 0", ov_cyc - o0); end
        send_frame(8'h22, 1'b1);
        drive(1'b1, 20);
        checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
            errors++; $display("FAIL overrun_hold: valid=%b data=%h want 1 11", bus.rx_valid, bus.rx_data); end
        checks++; if (ov_cyc - o0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d want 1", ov_cyc - o0); end
        checks++; if (got_n - g0 !== 0) begin errors++; $display("FAIL overrun_noaccept: got %0d want 0", got_n - g0); end
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_release: got %b want 0", bus.rx_valid); end
        checks++; if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h11 || bus.rx_data !== 8'h11) begin
            errors++; $display("FAIL overrun_accept: count %0d data %h want 1 11", got_n - g0, got_mem[g0[7:0]]); end
        drive(1'b1, 20);
    endtask

    task automatic test_reset_mid;
        int g0, v0, f0, o0;
        g0 = got_n; v0 = valid_cyc; f0 = fe_cyc; o0 = ov_cyc;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(1'b1, BIT);
        drive(1'b1, 40);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 6 * BIT);
        checks++; if (valid_cyc - v0 !== 0 || fe_cyc - f0 !== 0 || ov_cyc - o0 !== 0) begin
            errors++; $display("FAIL rstmid_quiet: valid=%0d fe=%0d ov=%0d want 0 0 0", valid_cyc - v0, fe_cyc - f0, ov_cyc - o0); end
        send_frame(8'h81, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== 1 || got_mem[g0[7:0]] !== 8'h81) begin
            errors++; $display("FAIL rstmid_next: count %0d data %h want 1 81", got_n - g0, got_mem[g0[7:0]]); end
    endtask

    task automatic test_back_to_back;
        int g0, f0, o0;
        g0 = got_n; f0 = fe_cyc; o0 = ov_cyc;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", got_n - g0); end
        checks++; if (got_mem[g0[7:0]] !== 8'h00 || got_mem[8'(g0 + 1)] !== 8'hFF) begin
            errors++; $display("FAIL b2b_data: got %h %h want 00 ff", got_mem[g0[7:0]], got_mem[8'(g0 + 1)]); end
        checks++; if (fe_cyc - f0 !== 0 || ov_cyc - o0 !== 0) begin
            errors++; $display("FAIL b2b_err: fe=%0d ov=%0d want 0 0", fe_cyc - f0, ov_cyc - o0); end
    endtask

    task automatic test_random;
        logic [7:0] exp_q [$];
        logic [7:0] d;
        logic       stop;
        int         g0, f0, o0, bad, gap;
        g0 = got_n; f0 = fe_cyc; o0 = ov_cyc; bad = 0;
        bus.rx_ready = 1'b1;
        for (int n = 0; n < 10; n++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            // A good stop delivers the byte; a low stop only flags an error.
            if (stop) begin
                exp_q.push_back(d);
                gap = $urandom_range(0, 40);
            end else begin
                bad++;
                gap = 20 + $urandom_range(0, 40);
            end
            drive(1'b1, gap);
        end
        drive(1'b1, 20);
        checks++; if (got_n - g0 !== exp_q.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", got_n - g0, exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++; if (got_mem[8'(g0 + k)] !== exp_q[k]) begin
                errors++; $display("FAIL rand_data[%0d]: got %h want %h", k, got_mem[8'(g0 + k)], exp_q[k]); end
        end
        checks++; if (fe_cyc - f0 !== bad) begin errors++; $display("FAIL rand_fe: got %0d want %0d", fe_cyc - f0, bad); end
        checks++; if (ov_cyc - o0 !== 0) begin errors++; $display("FAIL rand_ov: got %0d want 0", ov_cyc - o0); end
    endtask

    initial begin
        bus.rx       = 1'b1;
        bus.rx_ready = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 1000000, meaning system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, meaning serial bit rate in bit/s.
REQ-003 Parameter OVS, default 16, meaning oversampling ticks per bit (even, >=8).
REQ-004 clk  input  1  system clock, all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-007 rx_ready  input  1  consumer accepts rx_data when rx_valid&rx_ready.
REQ-008 rx_data  output  8  received byte, stable while rx_valid=1.
REQ-009 rx_valid  output  1  byte available, held until accepted.
REQ-010 framing_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-clk pulse: byte lost because previous byte unaccepted.

Function
REQ-012 rx SHALL pass a 2-FF synchronizer before any use; the synchronizer adds 2 clk latency.
REQ-013 Tick divider DIV = CLK_FREQ/(BAUD_RATE*OVS), integer truncation, minimum 1; one-clk tick pulse every DIV clks (defaults: DIV=6, bit = 96 clk), free-running.
REQ-014 FSM states IDLE, START, DATA, STOP; all state advances occur only on tick cycles.
REQ-015 IDLE: armed flag set on any tick with synced rx=1; on tick with rx=0 and armed -> START, tick counter=0.
REQ-016 START: at tick counter OVS/2-1 (mid-bit), rx=0 -> DATA with counters cleared; rx=1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: sample rx every OVS ticks at mid-bit; shift into bit 7 of a shift register, LSB first; after 8th sample -> STOP.
REQ-018 STOP: sample at mid-bit after OVS ticks; rx=1 -> byte complete; rx=0 -> framing_err pulse, byte discarded, armed cleared; both -> IDLE.
REQ-019 Byte complete with rx_valid=0, or with rx_valid&rx_ready in same clk: rx_data<=shift register, rx_valid=1 next clk, overrun=0.
REQ-020 Byte complete with rx_valid=1 and rx_ready=0: overrun pulse, rx_data and rx_valid unchanged (old byte kept).
REQ-021 rx_valid&rx_ready with no completion: rx_valid=0 next clk; rx_data holds last value.
REQ-022 rx_ready has no effect while rx_valid=0.
REQ-023 Latency: rx_valid rises within 1 clk of the stop-bit mid-sample tick.

Reset
REQ-024 On rst: state=IDLE, armed=0, counters=0, shift register=0, synchronizer=1s, rx_data=8'h00, rx_valid=0, framing_err=0, overrun=0.
REQ-025 rst mid-frame SHALL abandon the frame; no pulse or valid results from it.
REQ-026 rst has priority over every other event in the same clk.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enum (shared with the transmitter) and the DIV computation function.
REQ-028 Sub-module uart_baud_tick (DIV parameter, clk, rst, tick output) SHALL generate the oversample tick.
REQ-029 Target size 120-400 RTL lines; no memories, no FIFOs.

Verification (defaults, bit period 96 clk)
REQ-030 Send 8'hA5, 8N1, rx_ready=1 -> rx_valid one clk, rx_data=8'hA5, framing_err=0, overrun=0.
REQ-031 rx low pulse of 30 clk in IDLE -> no rx_valid, FSM returns to IDLE, next frame 8'h3C received correctly.
REQ-032 Frame 8'h55 with stop bit driven low -> framing_err one clk, rx_valid stays 0; after line high, frame 8'h0F received.
REQ-033 rx_ready=0, send 8'h11 then 8'h22 -> rx_data=8'h11 held, overrun pulses at second stop sample; set rx_ready=1 -> rx_valid falls next clk.
REQ-034 rst asserted during bit 4 of 8'hFF, released, then send 8'h81 -> only 8'h81 delivered.
REQ-035 Back-to-back 8'h00 then 8'hFF (zero idle gap) with rx_ready=1 -> both bytes delivered in order, no errors.
